// File: rtl/decode_redirect_arbiter_if.sv
// Redirect request/response bundle shared by the decode resolver, the backend recovery
// logic, fetch and decode_redirect_arbiter.
interface decode_redirect_arbiter_if #(
   parameter int PC_WIDTH      = 32,
   parameter int GHIST_WIDTH   = 10,
   parameter int RAS_PTR_WIDTH = 4
);
   logic                     dec_flush_valid;
   logic                     dec_stall;
   logic [PC_WIDTH-1:0]      dec_pc;
   logic [GHIST_WIDTH-1:0]   dec_ghist;
   logic [RAS_PTR_WIDTH-1:0] dec_ras_top;
   logic [RAS_PTR_WIDTH-1:0] dec_ras_tail;

   logic                     be_recover_valid;
   logic [PC_WIDTH-1:0]      be_pc;
   logic [GHIST_WIDTH-1:0]   be_ghist;
   logic [RAS_PTR_WIDTH-1:0] be_ras_top;
   logic [RAS_PTR_WIDTH-1:0] be_ras_tail;

   logic                     fetch_ready;

   logic                     redirect_valid;
   logic [PC_WIDTH-1:0]      redirect_pc;
   logic [GHIST_WIDTH-1:0]   redirect_ghist;
   logic [RAS_PTR_WIDTH-1:0] redirect_ras_top;
   logic [RAS_PTR_WIDTH-1:0] redirect_ras_tail;
   logic                     redirect_src;
   logic                     dec_redirect_accepted;
   logic                     dec_redirect_dropped;
   logic                     busy;

   // Arbiter side
   modport slave (
      input  dec_flush_valid, dec_stall, dec_pc, dec_ghist, dec_ras_top, dec_ras_tail,
      input  be_recover_valid, be_pc, be_ghist, be_ras_top, be_ras_tail,
      input  fetch_ready,
      output redirect_valid, redirect_pc, redirect_ghist, redirect_ras_top, redirect_ras_tail,
      output redirect_src, dec_redirect_accepted, dec_redirect_dropped, busy
   );

   // Requester / fetch side
   modport master (
      output dec_flush_valid, dec_stall, dec_pc, dec_ghist, dec_ras_top, dec_ras_tail,
      output be_recover_valid, be_pc, be_ghist, be_ras_top, be_ras_tail,
      output fetch_ready,
      input  redirect_valid, redirect_pc, redirect_ghist, redirect_ras_top, redirect_ras_tail,
      input  redirect_src, dec_redirect_accepted, dec_redirect_dropped, busy
   );
endinterface

// File: rtl/decode_redirect_arbiter.sv
// Arbitrates decode and backend fetch redirects into one registered slot, backend first,
// and drops wrong-path decode redirects for a short window after a backend redirect.
module decode_redirect_arbiter #(
   parameter int PC_WIDTH        = 32,
   parameter int GHIST_WIDTH     = 10,
   parameter int RAS_PTR_WIDTH   = 4,
   parameter int SUPPRESS_CYCLES = 2
) (
   input logic                        clk,
   input logic                        rst,
   decode_redirect_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING_DEC,
      ST_PENDING_BE,
      ST_SUPPRESS
   } state_t;

   localparam logic [3:0] LP_SUPPRESS = 4'(SUPPRESS_CYCLES);

   state_t                   r_state;
   logic [3:0]               r_cnt;
   logic                     r_valid;
   logic                     r_busy;
   logic                     r_src;
   logic [PC_WIDTH-1:0]      r_pc;
   logic [GHIST_WIDTH-1:0]   r_ghist;
   logic [RAS_PTR_WIDTH-1:0] r_ras_top;
   logic [RAS_PTR_WIDTH-1:0] r_ras_tail;

   logic w_dec_req;
   logic w_xfer;
   logic w_dec_accept;
   logic w_dec_drop;

   always_comb begin
      w_dec_req    = bus.dec_flush_valid && !bus.dec_stall;
      w_xfer       = r_valid && bus.fetch_ready;
      // Decode only wins from IDLE with no backend request; every other decode request is dropped.
      w_dec_accept = !rst && w_dec_req && (r_state == ST_IDLE) && !bus.be_recover_valid;
      w_dec_drop   = !rst && w_dec_req && !w_dec_accept;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_src      <= 1'b0;
         r_pc       <= '0;
         r_ghist    <= '0;
         r_ras_top  <= '0;
         r_ras_tail <= '0;
      end else begin
         // A backend request loads the slot in every state; the newest one always wins.
         if (bus.be_recover_valid) begin
            r_src      <= 1'b1;
            r_pc       <= bus.be_pc;
            r_ghist    <= bus.be_ghist;
            r_ras_top  <= bus.be_ras_top;
            r_ras_tail <= bus.be_ras_tail;
         end else if (w_dec_accept) begin
            r_src      <= 1'b0;
            r_pc       <= bus.dec_pc;
            r_ghist    <= bus.dec_ghist;
            r_ras_top  <= bus.dec_ras_top;
            r_ras_tail <= bus.dec_ras_tail;
         end

         case (r_state)
            ST_IDLE: begin
               if (bus.be_recover_valid) begin
                  r_state <= ST_PENDING_BE;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
               end else if (w_dec_req) begin
                  r_state <= ST_PENDING_DEC;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_PENDING_DEC: begin
               if (bus.be_recover_valid) begin
                  r_state <= ST_PENDING_BE;
               end else if (w_xfer) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            ST_PENDING_BE: begin
               if (!bus.be_recover_valid && w_xfer) begin
                  r_valid <= 1'b0;
                  if (LP_SUPPRESS == 4'd0) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_SUPPRESS;
                     r_cnt   <= LP_SUPPRESS;
                  end
               end
            end
            ST_SUPPRESS: begin
               if (bus.be_recover_valid) begin
                  r_state <= ST_PENDING_BE;
                  r_valid <= 1'b1;
                  r_cnt   <= '0;
               end else if (r_cnt <= 4'd1) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.redirect_valid        = r_valid;
   assign bus.redirect_pc           = r_pc;
   assign bus.redirect_ghist        = r_ghist;
   assign bus.redirect_ras_top      = r_ras_top;
   assign bus.redirect_ras_tail     = r_ras_tail;
   assign bus.redirect_src          = r_src;
   assign bus.dec_redirect_accepted = w_dec_accept;
   assign bus.dec_redirect_dropped  = w_dec_drop;
   assign bus.busy                  = r_busy;

endmodule

// File: doc/decode_redirect_arbiter.md
Name: decode_redirect_arbiter

Overview:
- Sits between the decode-stage branch resolver, the backend recovery logic (execute/commit) and the fetch unit.
- Collects fetch-redirect requests from decode (target PC, global history, RAS checkpoint) and from the backend, prioritises backend over decode, and holds the winner in a registered slot until fetch accepts it.
- After a backend redirect, suppresses wrong-path decode redirects for a programmable window.

Parameters:
PC_WIDTH, 32, width of redirect PC
GHIST_WIDTH, 10, width of branch global history
RAS_PTR_WIDTH, 4, width of each RAS checkpoint pointer (stack top, queue tail)
SUPPRESS_CYCLES, 2, cycles decode redirects are dropped after a backend redirect transfers (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
dec_flush_valid  in  1  decode resolver requests redirect
dec_stall  in  1  decode stalled; dec_flush_valid ignored while 1
dec_pc  in  PC_WIDTH  decode recovered PC
dec_ghist  in  GHIST_WIDTH  decode recovered history
dec_ras_top  in  RAS_PTR_WIDTH  decode RAS stack-top pointer
dec_ras_tail  in  RAS_PTR_WIDTH  decode RAS queue-tail pointer
be_recover_valid  in  1  backend recovery request
be_pc, be_ghist, be_ras_top, be_ras_tail  in  as dec_*  backend payload
fetch_ready  in  1  fetch accepts redirect this cycle
redirect_valid  out  1  pending redirect presented to fetch
redirect_pc, redirect_ghist, redirect_ras_top, redirect_ras_tail  out  as dec_*  pending payload
redirect_src  out  1  0 = decode, 1 = backend
dec_redirect_accepted  out  1  decode request latched this cycle (combinational)
dec_redirect_dropped  out  1  decode request discarded this cycle (combinational)
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock `clk`, synchronous active-high reset `rst`.
- Reset values:
  - state = IDLE, suppress counter = 0.
  - All redirect_* registers = 0, redirect_valid = 0.
  - busy = 0.
  - dec_redirect_accepted and dec_redirect_dropped are gated to 0 while rst = 1.
- Definitions:
  - dec_req = dec_flush_valid && !dec_stall.
  - xfer = redirect_valid && fetch_ready.
- States: IDLE, PENDING_DEC, PENDING_BE, SUPPRESS.
  - redirect_valid = 1 exactly in PENDING_DEC and PENDING_BE.
  - Outputs are driven from registers.
  - Latency from request to redirect_valid is 1 cycle.
- IDLE:
  - be_recover_valid: latch be_*, src = 1, go to PENDING_BE. If dec_req is also set, dec_redirect_dropped = 1.
  - dec_req alone: latch dec_*, src = 0, go to PENDING_DEC, dec_redirect_accepted = 1.
- PENDING_DEC:
  - be_recover_valid: overwrite the slot with be_*, src = 1, go to PENDING_BE. This applies even if xfer is set the same cycle; the decode redirect still counts as transferred that cycle.
  - Else if xfer: go to IDLE.
  - Any dec_req in this state: dropped.
- PENDING_BE:
  - be_recover_valid: overwrite the payload (the latest backend request always wins) and stay in PENDING_BE. If xfer is set the same cycle, the old payload transfers and the new one is held.
  - Else if xfer: load counter = SUPPRESS_CYCLES and go to SUPPRESS, or to IDLE when SUPPRESS_CYCLES = 0.
  - Any dec_req: dropped.
- SUPPRESS:
  - Counter decrements each cycle; leave for IDLE on the cycle it reads 1.
  - Any dec_req: dropped.
  - be_recover_valid: latch be_*, go to PENDING_BE, abandon the counter.
- Payload is held stable while redirect_valid && !fetch_ready, except for the backend overwrite cases above.
- dec_redirect_accepted and dec_redirect_dropped are mutually exclusive and never asserted when dec_req = 0.
- Reset asserted mid-operation discards any pending redirect; redirect_valid = 0 on the following cycle.
- No arithmetic; all payload fields are passed through unmodified.

Test Plan:
- Decode-only path: IDLE, dec_req with dec_pc = 0x1000_0040 and fetch_ready = 1 → accepted pulse same cycle; next cycle redirect_valid = 1, pc = 0x1000_0040, src = 0; the cycle after, IDLE and busy = 0.
- Simultaneous requests: dec_req (pc 0x100) and be_recover_valid (pc 0x200) in the same cycle → dropped = 1, accepted = 0; redirect_pc = 0x200, src = 1.
- Fetch backpressure: PENDING_DEC with fetch_ready = 0 for 3 cycles → payload stable; be_recover_valid (pc 0x300) in cycle 2 → pc becomes 0x300, src = 1; fetch_ready = 1 → SUPPRESS.
- Suppress window: SUPPRESS_CYCLES = 2, backend transfer at cycle T → dec_req at T+1 and T+2 dropped, dec_req at T+3 accepted; repeat with SUPPRESS_CYCLES = 0 → dec_req at T+1 accepted.
- Backend back-to-back: PENDING_BE (pc 0xA0), xfer and new be_recover_valid (pc 0xB0) in the same cycle → 0xA0 transferred, next cycle redirect_valid = 1 with pc 0xB0.
- Reset mid-pending: rst = 1 during PENDING_BE → next cycle redirect_valid = 0, busy = 0, all redirect_* = 0; dec_req under rst gives no pulses.
